// File: rtl/ula_seq_ctrl_if.sv
// Operand/opcode source, ULA drive/return and result handshake bundle
// for the ULA sequencing controller.
interface ula_seq_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_chain;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_s;
   logic             alu_ovf;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   modport master (
      input  in_data, in_chain, in_valid, alu_s, alu_ovf, out_ready,
      output in_ready, alu_sel, alu_a, alu_b, out_data, out_ovf,
             out_valid, busy, op_count
   );

   modport slave (
      output in_data, in_chain, in_valid, alu_s, alu_ovf, out_ready,
      input  in_ready, alu_sel, alu_a, alu_b, out_data, out_ovf,
             out_valid, busy, op_count
   );
endinterface

// File: rtl/ula_seq_ctrl.sv
// Collects A, B and opcode words, holds them stable for the ULA for one
// cycle, then presents the registered result until the consumer takes it.
module ula_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   ula_seq_ctrl_if.master bus
);
   typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, RESP} state_t;

   state_t state, state_nxt;

   logic             in_rdy;
   logic             out_vld;
   logic             bsy;
   logic             in_xfer;
   logic             out_xfer;
   logic             chain_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       sel_q;
   logic [WIDTH-1:0] s_q;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;

   assign in_xfer  = bus.in_valid && in_rdy;
   assign out_xfer = out_vld && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= GET_A;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         GET_A:   if (in_xfer) state_nxt = GET_B;
         GET_B:   if (in_xfer) state_nxt = GET_OP;
         GET_OP:  if (in_xfer) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (out_xfer) state_nxt = chain_q ? GET_B : GET_A;
         default: state_nxt = GET_A;
      endcase
   end

   always_comb begin
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      bsy     = 1'b0;
      case (state)
         GET_A, GET_B, GET_OP: in_rdy = 1'b1;
         EXEC:                 bsy    = 1'b1;
         RESP: begin
            out_vld = 1'b1;
            bsy     = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand, result and counter registers; each only moves at its own edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         chain_q <= 1'b0;
         s_q     <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state)
            GET_A:  if (in_xfer) a_q <= bus.in_data;
            GET_B:  if (in_xfer) b_q <= bus.in_data;
            GET_OP: if (in_xfer) begin
               sel_q   <= bus.in_data[1:0];
               chain_q <= bus.in_chain;
            end
            EXEC: begin
               s_q   <= bus.alu_s;
               ovf_q <= bus.alu_ovf;
            end
            RESP: if (out_xfer) begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (chain_q) a_q <= s_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.busy      = bsy;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_sel   = sel_q;
   assign bus.out_data  = s_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed bench for ula_seq_ctrl: two instances (8-bit and 2-bit counter)
// share stimulus, each driving its own behavioural ULA.
module tb_ula_seq_ctrl;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ula_seq_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();
   ula_seq_ctrl_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

   ula_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
   ula_seq_ctrl #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // Behavioural ULA: {ovf, s}
   function automatic logic [4:0] ula(input logic [1:0] sel, input logic [3:0] a,
                                      input logic [3:0] b);
      logic [4:0] w;
      case (sel)
         2'd0:    w = {1'b0, a} + {1'b0, b};
         2'd1:    w = {1'b0, a} - {1'b0, b};
         2'd2:    w = {1'b0, a >> b};
         default: w = {1'b0, a} << b;
      endcase
      return w;
   endfunction

   assign {bus.alu_ovf, bus.alu_s}   = ula(bus.alu_sel, bus.alu_a, bus.alu_b);
   assign {bus2.alu_ovf, bus2.alu_s} = ula(bus2.alu_sel, bus2.alu_a, bus2.alu_b);

   assign bus2.in_data   = bus.in_data;
   assign bus2.in_chain  = bus.in_chain;
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.out_ready = bus.out_ready;

   int checks = 0;
   int fails  = 0;
   int ops    = 0;
   logic [4:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d, input logic ch, input string tag);
      int n = 0;
      bus.in_data  = d;
      bus.in_chain = ch;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic ch, input logic [3:0] es, input logic eo, input string tag);
      send(a, 1'b0, {tag, "_a"});
      send(b, 1'b0, {tag, "_b"});
      send({2'b00, op}, ch, {tag, "_op"});
      exp_q.push_back({eo, es});
   endtask

   task automatic get_res(input string tag);
      int n = 0;
      logic [4:0] e;
      bus.out_ready = 1'b1;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      chk({tag, "_out_data"}, 32'(bus.out_data), 32'(e[3:0]));
      chk({tag, "_out_ovf"}, 32'(bus.out_ovf), 32'(e[4]));
      tick();
      ops++;
      bus.out_ready = 1'b0;
      chk({tag, "_op_count"}, 32'(bus.op_count), 32'(ops[7:0]));
      chk({tag, "_op_count_w2"}, 32'(bus2.op_count), 32'(ops[1:0]));
   endtask

   initial begin
      logic [1:0] seq2 [5];
      seq2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rst           = 1'b1;
      bus.in_data   = '0;
      bus.in_chain  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
      chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_op_count", 32'(bus.op_count), 32'd0);

      // 5 + 3 with latency check
      send(4'd5, 1'b0, "add_a");
      send(4'd3, 1'b0, "add_b");
      send(4'd0, 1'b0, "add_op");
      exp_q.push_back({1'b0, 4'd8});
      chk("exec_out_valid", 32'(bus.out_valid), 32'd0);
      chk("exec_busy", 32'(bus.busy), 32'd1);
      chk("exec_in_ready", 32'(bus.in_ready), 32'd0);
      chk("exec_alu_a", 32'(bus.alu_a), 32'd5);
      chk("exec_alu_b", 32'(bus.alu_b), 32'd3);
      chk("exec_alu_sel", 32'(bus.alu_sel), 32'd0);
      tick();
      chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
      get_res("add58");
      chk("post_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_busy", 32'(bus.busy), 32'd0);

      do_op(4'd9, 4'd9, 2'd0, 1'b0, 4'd2, 1'b1, "add99");
      get_res("add99");
      do_op(4'd3, 4'd5, 2'd1, 1'b0, 4'd14, 1'b1, "sub35");
      get_res("sub35");
      do_op(4'd12, 4'd2, 2'd2, 1'b0, 4'd3, 1'b0, "shr122");
      get_res("shr122");

      // shl with consumer stalled while the source keeps offering a word
      do_op(4'd9, 4'd1, 2'd3, 1'b0, 4'd2, 1'b1, "shl91");
      tick();
      bus.in_data  = 4'd7;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_out_data", 32'(bus.out_data), 32'd2);
         chk("stall_out_ovf", 32'(bus.out_ovf), 32'd1);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_op_count", 32'(bus.op_count), 32'(ops[7:0]));
         tick();
      end
      bus.in_valid = 1'b0;
      get_res("shl91");

      // chained accumulation: second op reuses result as A
      do_op(4'd1, 4'd2, 2'd0, 1'b1, 4'd3, 1'b0, "chain1");
      get_res("chain1");
      chk("chain_reload_a", 32'(bus.alu_a), 32'd3);
      chk("chain_in_ready", 32'(bus.in_ready), 32'd1);
      send(4'd4, 1'b0, "chain2_b");
      send(4'd0, 1'b0, "chain2_op");
      exp_q.push_back({1'b0, 4'd7});
      chk("chain2_exec_alu_a", 32'(bus.alu_a), 32'd3);
      get_res("chain2");

      // reset mid-sequence drops collected operands
      send(4'd6, 1'b0, "rstop_a");
      send(4'd2, 1'b0, "rstop_b");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ops = 0;
      chk("rstop_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rstop_alu_b", 32'(bus.alu_b), 32'd0);
      chk("rstop_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rstop_op_count", 32'(bus.op_count), 32'd0);
      do_op(4'd1, 4'd1, 2'd0, 1'b0, 4'd2, 1'b0, "after_rst");
      get_res("after_rst");

      // reset while a result is pending
      do_op(4'd2, 4'd2, 2'd0, 1'b0, 4'd4, 1'b0, "rstresp");
      tick();
      tick();
      chk("rstresp_pending", 32'(bus.out_valid), 32'd1);
      void'(exp_q.pop_front());
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ops = 0;
      chk("rstresp_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rstresp_op_count", 32'(bus.op_count), 32'd0);
      chk("rstresp_op_count_w2", 32'(bus2.op_count), 32'd0);
      chk("rstresp_busy", 32'(bus.busy), 32'd0);
      chk("rstresp_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rstresp_out_data", 32'(bus.out_data), 32'd0);

      // counter wrap on the 2-bit instance
      for (int i = 0; i < 5; i++) begin
         do_op(4'(i), 4'd1, 2'd0, 1'b0, 4'(i + 1), 1'b0, "wrap");
         get_res("wrap");
         chk("wrap_seq", 32'(bus2.op_count), 32'(seq2[i]));
      end

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
